// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// motor_pkg
// Shared command types for the motor decision FSMs, scheduler and driver.
// Rev 1.0 - initial release
// ============================================================================
package motor_pkg;

  typedef enum logic [2:0] {
    DIR_STOP     = 3'd0,
    DIR_FORWARD  = 3'd1,
    DIR_BACKWARD = 3'd2,
    DIR_LEFT     = 3'd3,
    DIR_RIGHT    = 3'd4
  } dir_t;

  typedef enum logic [2:0] {
    ST_DWELL     = 3'd0,
    ST_RUN       = 3'd1,
    ST_RAMP_DOWN = 3'd2,
    ST_ESTOP     = 3'd3
  } sched_state_t;

  typedef logic [2:0] speed_t;

  // Unused encodings are folded onto STOP so they can never move the motor.
  function automatic dir_t norm_dir(logic [2:0] raw);
    if (raw > 3'd4) return DIR_STOP;
    return dir_t'(raw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_timer.sv
`default_nettype none
// ============================================================================
// pulse_timer
// Down-counter that emits a one-cycle pulse every PERIOD enabled clocks.
// Rev 1.0 - initial release
// ============================================================================
module pulse_timer #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic enable,
  output logic pulse
);

  localparam int c_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [c_W-1:0] c_LOAD = c_W'(PERIOD - 1);

  logic [c_W-1:0] r_cnt;

  assign pulse = enable && !reload && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= c_LOAD;
    end else if (reload || pulse) begin
      r_cnt <= c_LOAD;
    end else if (enable) begin
      r_cnt <= r_cnt - c_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/motor_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// motor_cmd_scheduler
// Ramps speed, enforces a stop-dwell before reversals, handles emergency stop
// and presents commands to the motor driver over valid/ready with keep-alive.
// Rev 1.0 - initial release
// ============================================================================
module motor_cmd_scheduler
  import motor_pkg::*;
#(
  parameter int         RAMP_CYCLES    = 5_000_000,
  parameter int         DWELL_CYCLES   = 10_000_000,
  parameter int         REFRESH_CYCLES = 25_000_000,
  parameter logic [7:0] TOO_CLOSE      = 8'd20,
  parameter logic [7:0] CLEAR_HYST     = 8'd5
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [2:0] req_direction,
  input  logic [2:0] req_speed,
  input  logic [7:0] distance,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_direction,
  output logic [2:0] cmd_speed,
  output logic       estop,
  output logic [2:0] state_dbg
);

  localparam logic [8:0] c_RELEASE = {1'b0, TOO_CLOSE} + {1'b0, CLEAR_HYST};

  sched_state_t r_state, w_nxt_state;
  dir_t         r_cur_dir, w_nxt_dir, w_req_dir;
  speed_t       r_cur_spd, w_nxt_spd, w_tgt_spd;
  logic         r_pending, r_estop, r_dwell_expired;
  logic         w_tick, w_dwell_pulse, w_refresh_pulse, w_dwell_reload;
  logic         w_stall, w_accept, w_change, w_nxt_pending;
  logic         w_estop_trig, w_release, w_dwell_done;

  assign w_req_dir    = norm_dir(req_direction);
  assign w_tgt_spd    = (w_req_dir == DIR_STOP) ? speed_t'(0) : req_speed;
  assign w_accept     = r_pending && cmd_ready;
  assign w_stall      = r_pending && !cmd_ready;
  assign w_estop_trig = (distance < TOO_CLOSE) &&
                        ((r_cur_dir == DIR_FORWARD) || (w_req_dir == DIR_FORWARD));
  assign w_release    = ({1'b0, distance} >= c_RELEASE) ||
                        ((w_req_dir != DIR_FORWARD) && (w_req_dir != DIR_STOP));
  assign w_dwell_done = w_dwell_pulse || r_dwell_expired;
  assign w_dwell_reload = (w_nxt_state == ST_DWELL) && (r_state != ST_DWELL);

  pulse_timer #(.PERIOD(RAMP_CYCLES)) u_ramp_tick (
    .clk(CLOCK_50), .rst_n(reset_n), .reload(1'b0), .enable(1'b1), .pulse(w_tick)
  );

  pulse_timer #(.PERIOD(DWELL_CYCLES)) u_dwell (
    .clk(CLOCK_50), .rst_n(reset_n), .reload(w_dwell_reload),
    .enable((r_state == ST_DWELL) && (w_req_dir != DIR_STOP)), .pulse(w_dwell_pulse)
  );

  // Expiry re-raises valid one clock later and acceptance takes one more, so
  // one clock shorter here makes accepted keep-alives REFRESH_CYCLES apart.
  pulse_timer #(.PERIOD(REFRESH_CYCLES - 1)) u_refresh (
    .clk(CLOCK_50), .rst_n(reset_n), .reload(w_accept), .enable(1'b1),
    .pulse(w_refresh_pulse)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_dir   = r_cur_dir;
    w_nxt_spd   = r_cur_spd;
    if (w_estop_trig) begin
      w_nxt_state = ST_ESTOP;
      w_nxt_dir   = DIR_STOP;
      w_nxt_spd   = '0;
    end else begin
      case (r_state)
        ST_DWELL: begin
          if (w_dwell_done && (w_req_dir != DIR_STOP) && !w_stall) begin
            w_nxt_state = ST_RUN;
            w_nxt_dir   = w_req_dir;
          end
        end
        ST_RUN: begin
          if (w_req_dir != r_cur_dir) begin
            if (r_cur_spd != '0) begin
              w_nxt_state = ST_RAMP_DOWN;
            end else if (!w_stall) begin
              w_nxt_state = ST_DWELL;
              w_nxt_dir   = DIR_STOP;
            end
          end else if (w_tick && !w_stall) begin
            if (r_cur_spd < w_tgt_spd) begin
              w_nxt_spd = r_cur_spd + 3'd1;
            end else if (r_cur_spd > w_tgt_spd) begin
              w_nxt_spd = r_cur_spd - 3'd1;
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (!w_stall) begin
            if (r_cur_spd == '0) begin
              w_nxt_state = ST_DWELL;
              w_nxt_dir   = DIR_STOP;
            end else if (w_tick) begin
              w_nxt_spd = r_cur_spd - 3'd1;
            end
          end
        end
        ST_ESTOP: begin
          if (w_release) w_nxt_state = ST_DWELL;
        end
        default: begin
          w_nxt_state = ST_DWELL;
          w_nxt_dir   = DIR_STOP;
          w_nxt_spd   = '0;
        end
      endcase
    end
  end

  // A fresh change wins over a same-cycle acceptance so the new payload is offered.
  assign w_change      = (w_nxt_dir != r_cur_dir) || (w_nxt_spd != r_cur_spd);
  assign w_nxt_pending = w_change || (!w_accept && (r_pending || w_refresh_pulse));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_DWELL;
      r_cur_dir       <= DIR_STOP;
      r_cur_spd       <= '0;
      r_pending       <= 1'b1;
      r_estop         <= 1'b0;
      r_dwell_expired <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cur_dir <= w_nxt_dir;
      r_cur_spd <= w_nxt_spd;
      r_pending <= w_nxt_pending;
      r_estop   <= (w_nxt_state == ST_ESTOP);
      if (w_dwell_reload) begin
        r_dwell_expired <= 1'b0;
      end else if (w_dwell_pulse) begin
        r_dwell_expired <= 1'b1;
      end
    end
  end

  assign cmd_valid     = r_pending;
  assign cmd_direction = r_cur_dir;
  assign cmd_speed     = r_cur_spd;
  assign estop         = r_estop;
  assign state_dbg     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// tb_motor_cmd_scheduler
// Directed self-checking bench for motor_cmd_scheduler (RAMP=4, DWELL=8, REFRESH=64).
// Rev 1.0 - initial release
// ============================================================================
module tb_motor_cmd_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic [2:0] req_direction;
  logic [2:0] req_speed;
  logic [7:0] distance;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_direction;
  logic [2:0] cmd_speed;
  logic       estop;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int t        = 0;

  motor_cmd_scheduler #(
    .RAMP_CYCLES(4), .DWELL_CYCLES(8), .REFRESH_CYCLES(64),
    .TOO_CLOSE(8'd20), .CLEAR_HYST(8'd5)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .req_direction(req_direction),
    .req_speed(req_speed), .distance(distance), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_direction(cmd_direction), .cmd_speed(cmd_speed),
    .estop(estop), .state_dbg(state_dbg)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic chk_v(input string tag, input logic v);
    check({tag, ".valid"}, {2'b0, cmd_valid}, {2'b0, v});
  endtask

  task automatic chk_ds(input string tag, input logic [2:0] d, input logic [2:0] s);
    check({tag, ".dir"}, cmd_direction, d);
    check({tag, ".spd"}, cmd_speed, s);
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st, input logic e);
    check({tag, ".state"}, state_dbg, st);
    check({tag, ".estop"}, {2'b0, estop}, {2'b0, e});
  endtask

  // Advance to the falling edge following rising edge number 'target'.
  task automatic goto(input int target);
    repeat (target - t) @(negedge CLOCK_50);
    t = target;
  endtask

  initial begin
    reset_n       = 1'b0;
    req_direction = 3'd1;
    req_speed     = 3'd5;
    distance      = 8'd255;
    cmd_ready     = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    chk_v("reset", 1'b1);
    chk_ds("reset", 3'd0, 3'd0);
    chk_st("reset", 3'd0, 1'b0);

    // Release: STOP/0 offered, dwell of 8 clocks, then FORWARD ramps 1..5.
    reset_n = 1'b1;
    t = 0;
    #1;
    chk_v("first_offer", 1'b1);
    goto(1);  chk_v("first_accept", 1'b0); chk_st("dwell0", 3'd0, 1'b0);
    goto(7);  chk_ds("dwell_hold", 3'd0, 3'd0); chk_st("dwell_hold", 3'd0, 1'b0);
    goto(8);  chk_st("run_entry", 3'd1, 1'b0); chk_ds("run_entry", 3'd1, 3'd0);
    chk_v("run_entry", 1'b1);
    for (int s = 1; s <= 5; s++) begin
      goto(8 + 4 * s - 1); chk_ds("ramp_pre", 3'd1, 3'(s - 1));
      goto(8 + 4 * s);     chk_ds("ramp_step", 3'd1, 3'(s));
    end
    goto(32); chk_ds("ramp_sat", 3'd1, 3'd5);

    // Reversal FORWARD/5 -> BACKWARD/3.
    req_direction = 3'd2; req_speed = 3'd3;
    goto(33); chk_st("rampdn_entry", 3'd2, 1'b0); chk_ds("rampdn_entry", 3'd1, 3'd5);
    for (int k = 1; k <= 5; k++) begin
      goto(32 + 4 * k); chk_ds("rampdn", 3'd1, 3'(5 - k));
    end
    goto(53); chk_st("rev_dwell", 3'd0, 1'b0); chk_ds("rev_dwell", 3'd0, 3'd0);
    goto(60); chk_ds("rev_dwell_end", 3'd0, 3'd0);
    goto(61); chk_st("rev_run", 3'd1, 1'b0); chk_ds("rev_run", 3'd2, 3'd0);
    for (int s = 1; s <= 3; s++) begin
      goto(60 + 4 * s); chk_ds("rev_ramp", 3'd2, 3'(s));
    end

    // Back to FORWARD/4, then obstacle emergency stop with hysteresis.
    req_direction = 3'd1; req_speed = 3'd4;
    goto(73);  chk_st("rev2_rampdn", 3'd2, 1'b0);
    goto(85);  chk_ds("rev2_dwell", 3'd0, 3'd0);
    goto(93);  chk_ds("rev2_run", 3'd1, 3'd0);
    goto(108); chk_ds("fwd4", 3'd1, 3'd4);
    goto(110); distance = 8'd19;
    goto(111); chk_st("estop_in", 3'd3, 1'b1); chk_ds("estop_in", 3'd0, 3'd0);
    chk_v("estop_in", 1'b1);
    goto(113); distance = 8'd24;
    goto(116); chk_st("estop_hyst", 3'd3, 1'b1);
    distance = 8'd25;
    goto(117); chk_st("estop_out", 3'd0, 1'b0);

    // Back-pressure: payload frozen, step stalls, ESTOP overrides the payload.
    goto(125); chk_ds("bp_run", 3'd1, 3'd0);
    goto(128); chk_ds("bp_spd1", 3'd1, 3'd1);
    goto(129); chk_v("bp_idle", 1'b0);
    cmd_ready = 1'b0;
    goto(132); chk_ds("bp_spd2", 3'd1, 3'd2); chk_v("bp_spd2", 1'b1);
    goto(136); chk_ds("bp_stall", 3'd1, 3'd2); chk_v("bp_stall", 1'b1);
    goto(140); chk_ds("bp_stall2", 3'd1, 3'd2);
    goto(141); distance = 8'd10;
    goto(142); chk_ds("bp_estop", 3'd0, 3'd0); chk_st("bp_estop", 3'd3, 1'b1);
    chk_v("bp_estop", 1'b1);
    goto(143); distance = 8'd255; cmd_ready = 1'b1;
    goto(144); chk_v("bp_accept", 1'b0); chk_st("bp_accept", 3'd0, 1'b0);
    goto(146); chk_v("bp_once", 1'b0);

    // Steady FORWARD/3: keep-alive accepted every 64 clocks.
    req_speed = 3'd3;
    goto(152); chk_st("ka_run", 3'd1, 1'b0); chk_ds("ka_run", 3'd1, 3'd0);
    goto(164); chk_ds("ka_spd3", 3'd1, 3'd3);
    goto(165); chk_v("ka_accepted", 1'b0);
    goto(227); chk_v("ka_quiet", 1'b0);
    goto(228); chk_v("ka_resend1", 1'b1); chk_ds("ka_resend1", 3'd1, 3'd3);
    goto(229); chk_v("ka_accept1", 1'b0);
    goto(291); chk_v("ka_quiet2", 1'b0);
    goto(292); chk_v("ka_resend2", 1'b1);
    goto(293); chk_v("ka_accept2", 1'b0);

    // Asynchronous reset mid-ramp with an unaccepted command outstanding.
    req_speed = 3'd6;
    goto(296); chk_ds("mid_ramp", 3'd1, 3'd4); chk_v("mid_ramp", 1'b1);
    cmd_ready = 1'b0;
    @(posedge CLOCK_50);
    #2;
    reset_n = 1'b0;
    #1;
    chk_v("async_rst", 1'b1);
    chk_ds("async_rst", 3'd0, 3'd0);
    chk_st("async_rst", 3'd0, 1'b0);
    cmd_ready = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    t = 0;
    goto(1);  chk_v("rst2_accept", 1'b0);
    goto(8);  chk_st("rst2_run", 3'd1, 1'b0); chk_ds("rst2_run", 3'd1, 3'd0);
    goto(12); chk_ds("rst2_ramp", 3'd1, 3'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/motor_cmd_scheduler.md
# motor_cmd_scheduler

Sequences drive commands between the decision FSMs (direction/speed) and the UART motor driver. It ramps speed one step at a time and forces a stop-dwell before any direction reversal. An obstacle emergency stop overrides all other requests. It presents each command to the driver over a valid/ready handshake and periodically re-sends the current command as a keep-alive.

## Interface
- RAMP_CYCLES, 5_000_000: clocks between speed steps (100 ms @ 50 MHz)
- DWELL_CYCLES, 10_000_000: stopped time before a new direction is applied
- REFRESH_CYCLES, 25_000_000: keep-alive period since last accepted command
- TOO_CLOSE, 8'd20: emergency-stop distance (cm)
- CLEAR_HYST, 8'd5: release margin above TOO_CLOSE
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_direction  in  3  requested dir_t
- req_speed  in  3  requested speed, 0..7
- distance  in  8  ultrasonic distance (cm)
- cmd_ready  in  1  driver accepts command
- cmd_valid  out  1  command available
- cmd_direction  out  3  dir_t payload
- cmd_speed  out  3  speed payload
- estop  out  1  emergency stop active
- state_dbg  out  3  current state encoding, for LEDR

## Operation
- dir_t encoding: STOP=0, FORWARD=1, BACKWARD=2, LEFT=3, RIGHT=4. Other values are treated as STOP.
- Internal cur_dir/cur_spd: the command last generated. Effective target speed is 0 when req_direction is STOP.
- A free-running tick fires every RAMP_CYCLES clocks.
- States:
  - DWELL: cur_dir=STOP, cur_spd=0, counts DWELL_CYCLES, then cur_dir=req_direction and goes to RUN. If req_direction is STOP, it stays in DWELL with the counter held.
  - RUN: on tick, cur_spd steps ±1 toward req_speed (saturating 0..7). If req_direction≠cur_dir, goes to RAMP_DOWN, or straight to DWELL if cur_spd=0.
  - RAMP_DOWN: on tick, cur_spd-=1. At cur_spd=0, goes to DWELL.
  - ESTOP: entered from any state when distance<TOO_CLOSE and (cur_dir or req_direction)=FORWARD. cur_dir=STOP and cur_spd=0 are set immediately and estop=1. Exits to DWELL when distance≥TOO_CLOSE+CLEAR_HYST, or when req_direction∉{FORWARD, STOP}.
- Emission:
  - Any change of (cur_dir, cur_spd) sets pending.
  - cmd_valid=pending. The payload is the registered cur_dir/cur_spd.
  - cmd_valid&cmd_ready clears pending and restarts the refresh counter.
  - Refresh expiry with pending=0 sets pending with an unchanged payload.
- Handshake:
  - The payload is stable while cmd_valid&!cmd_ready.
  - RUN/RAMP_DOWN steps and DWELL exit stall while unaccepted.
  - Exception: ESTOP entry overwrites the payload with STOP/0 even while unaccepted. The driver captures the payload only at acceptance.
- Simultaneous events:
  - ESTOP beats tick, dwell expiry and refresh.
  - Acceptance and a new change in the same cycle: pending stays 1 with the new payload.
- Reset: state=DWELL (counter loaded), pending=1, so STOP/0 is offered on the first cycle after release.

## Timing
- Reset values: cmd_valid=1, cmd_direction=STOP, cmd_speed=0, estop=0, state_dbg=DWELL. All outputs are registered.
- Inputs are sampled on each CLOCK_50 rising edge. Effects appear on outputs one clock later.
- ESTOP latency: estop and STOP/0 payload appear 1 clock after distance<TOO_CLOSE is sampled.
- Speed ramp 0→7 takes 7 ticks. A full reversal takes cur_spd ticks down, then DWELL_CYCLES, then ramp up.
- Counters are sized to $clog2 of each parameter and reload on state entry (dwell) or on acceptance (refresh).
- Reset asserted mid-ramp or mid-handshake aborts immediately to reset values.

## Structure
- Shared package motor_pkg: dir_t enum, sched_state_t enum (DWELL, RUN, RAMP_DOWN, ESTOP), speed_t (logic [2:0]). direction_fsm, speed_fsm and drive_motor import it as well.
- One sub-module: pulse_timer (parameterised period, reload/enable inputs, one-cycle pulse out). Used for the ramp tick, dwell and refresh.

## Test plan
Parameters for all scenarios: RAMP=4, DWELL=8, REFRESH=64, cmd_ready tied 1 unless stated.
- Release reset -> cmd_valid=1 with STOP/0 next cycle. After dwell, req FORWARD/5 yields speeds 1..5, one step every 4 clocks.
- RUN FORWARD/5, req BACKWARD/3 -> speeds 4,3,2,1,0 forward; STOP held 8 clocks; then BACKWARD 1,2,3.
- RUN FORWARD/4, distance=19 -> next cycle estop=1 with STOP/0. distance=24 keeps ESTOP; distance=25 -> DWELL.
- cmd_ready=0 during RUN ramp -> payload frozen and speed steps stall. Assert ESTOP while frozen -> payload becomes STOP/0. cmd_ready=1 -> accepted once.
- Steady FORWARD/3 with no changes -> a re-sent FORWARD/3 is accepted every 64 clocks.
- Assert reset_n=0 mid-ramp at speed 4 -> outputs go to reset values asynchronously; resume from DWELL after release.
